// File: rtl/stack_calc_core_if.sv
// Command/response channel of the stack calculator core.
// The master issues commands and receives the one-cycle done pulse.
// The slave is the core, which accepts commands and returns the response.
interface stack_calc_core_if #(
  parameter int WIDTH = 8
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_err;
  logic             rsp_carry;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_err,
    input  rsp_carry
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready,
    output rsp_valid,
    output rsp_err,
    output rsp_carry
  );

endinterface

// File: rtl/stack_calc_core.sv
// Stack-machine calculator core.
// A DEPTH x WIDTH stack lives in a synchronous RAM and grows down from
// DEPTH-1. Commands come in on a valid/ready port; every accepted command
// ends with a one-cycle rsp_valid pulse. dvr/dar drive the display front end.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a command, error checks made on accept
// RD    | RAM read address = dar (POP/TOP/DAR_INC/DAR_DEC)
// CAP   | capture RAM word into dvr
// RDA   | RAM read address = top (operand A)
// RDB   | RAM read address = top+1, capture A
// CAPB  | capture B, compute result and carry/borrow
// WR    | write PUSH operand or ADD/SUB result, update count/dar/dvr
// DONE  | rsp_* valid for one cycle
module stack_calc_core #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 128,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  stack_calc_core_if.slave  cmd_if,
  output logic [WIDTH-1:0]  dvr,
  output logic [ADDR_W-1:0] dar,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_RDA  = 3'd3;
  localparam logic [2:0] S_RDB  = 3'd4;
  localparam logic [2:0] S_CAPB = 3'd5;
  localparam logic [2:0] S_WR   = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [2:0] OP_PUSH    = 3'd0;
  localparam logic [2:0] OP_POP     = 3'd1;
  localparam logic [2:0] OP_ADD     = 3'd2;
  localparam logic [2:0] OP_SUB     = 3'd3;
  localparam logic [2:0] OP_TOP     = 3'd4;
  localparam logic [2:0] OP_CLEAR   = 3'd5;
  localparam logic [2:0] OP_DAR_INC = 3'd6;
  localparam logic [2:0] OP_DAR_DEC = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] dar_q, dar_d;
  logic [WIDTH-1:0]  dvr_q, dvr_d;
  logic              err_q, err_d;
  logic              carry_q, carry_d;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [WIDTH-1:0]  rd_data_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              we;

  logic [ADDR_W-1:0] top_addr;
  logic [ADDR_W-1:0] top_p1;
  logic [ADDR_W-1:0] free_addr;
  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    diff;
  logic              is_full;
  logic              is_empty;

  // DEPTH is a power of two, so DEPTH-count mod DEPTH is just -count on the
  // low address bits; the count MSB only matters when count==DEPTH (top=0).
  assign top_addr  = {ADDR_W{1'b0}} - count_q[ADDR_W-1:0];
  assign top_p1    = top_addr + 1'b1;
  assign free_addr = top_addr - 1'b1;

  // B is the RAM word arriving in CAPB, A was captured one cycle earlier.
  assign sum  = {1'b0, rd_data_q} + {1'b0, a_q};
  assign diff = {1'b0, rd_data_q} - {1'b0, a_q};

  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign is_empty = (count_q == '0);

  assign cmd_if.cmd_ready = (state_q == S_IDLE);
  assign cmd_if.rsp_valid = (state_q == S_DONE);
  assign cmd_if.rsp_err   = (state_q == S_DONE) & err_q;
  assign cmd_if.rsp_carry = (state_q == S_DONE) & carry_q;

  assign dvr   = dvr_q;
  assign dar   = dar_q;
  assign count = count_q;
  assign empty = is_empty;
  assign full  = is_full;

  // Next-state logic: command decode on accept, then the per-op sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    a_d     = a_q;
    res_d   = res_q;
    count_d = count_q;
    dar_d   = dar_q;
    dvr_d   = dvr_q;
    err_d   = err_q;
    carry_d = carry_q;
    rd_addr = dar_q;
    wr_addr = free_addr;
    wr_data = data_q;
    we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_if.cmd_valid) begin
          op_d    = cmd_if.cmd_op;
          data_d  = cmd_if.cmd_data;
          err_d   = 1'b0;
          carry_d = 1'b0;
          case (cmd_if.cmd_op)
            OP_PUSH: begin
              if (is_full) begin
                err_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d = S_WR;
              end
            end
            OP_POP: begin
              if (is_empty) begin
                err_d   = 1'b1;
                state_d = S_DONE;
              end else if (count_q == CNT_W'(1)) begin
                count_d = '0;
                dar_d   = '0;
                dvr_d   = '0;
                state_d = S_DONE;
              end else begin
                count_d = count_q - 1'b1;
                dar_d   = top_p1;
                state_d = S_RD;
              end
            end
            OP_TOP: begin
              if (is_empty) begin
                err_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                dar_d   = top_addr;
                state_d = S_RD;
              end
            end
            OP_ADD, OP_SUB: begin
              if (count_q < CNT_W'(2)) begin
                err_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                state_d = S_RDA;
              end
            end
            OP_CLEAR: begin
              count_d = '0;
              dar_d   = '0;
              dvr_d   = '0;
              state_d = S_DONE;
            end
            OP_DAR_INC: begin
              dar_d   = dar_q + 1'b1;
              state_d = S_RD;
            end
            default: begin
              dar_d   = dar_q - 1'b1;
              state_d = S_RD;
            end
          endcase
        end
      end
      S_RD: begin
        rd_addr = dar_q;
        state_d = S_CAP;
      end
      S_CAP: begin
        dvr_d   = rd_data_q;
        state_d = S_DONE;
      end
      S_RDA: begin
        rd_addr = top_addr;
        state_d = S_RDB;
      end
      S_RDB: begin
        rd_addr = top_p1;
        a_d     = rd_data_q;
        state_d = S_CAPB;
      end
      S_CAPB: begin
        if (op_q == OP_SUB) begin
          res_d   = diff[WIDTH-1:0];
          carry_d = diff[WIDTH];
        end else begin
          res_d   = sum[WIDTH-1:0];
          carry_d = sum[WIDTH];
        end
        state_d = S_WR;
      end
      S_WR: begin
        we = 1'b1;
        if (op_q == OP_PUSH) begin
          wr_addr = free_addr;
          wr_data = data_q;
          dar_d   = free_addr;
          dvr_d   = data_q;
          count_d = count_q + 1'b1;
        end else begin
          wr_addr = top_p1;
          wr_data = res_q;
          dar_d   = top_p1;
          dvr_d   = res_q;
          count_d = count_q - 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and architectural registers; reset discards any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_PUSH;
      data_q  <= '0;
      a_q     <= '0;
      res_q   <= '0;
      count_q <= '0;
      dar_q   <= '0;
      dvr_q   <= '0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      a_q     <= a_d;
      res_q   <= res_d;
      count_q <= count_d;
      dar_q   <= dar_d;
      dvr_q   <= dvr_d;
      err_q   <= err_d;
      carry_q <= carry_d;
    end
  end

  // Stack RAM: one write port, one registered read port, contents not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_stack_calc_core.sv
// Bench for stack_calc_core: a table of command/response vectors run through
// a scoreboard queue, then hand-written fill, address-wrap and reset sequences.
module tb_stack_calc_core;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 8;

  localparam logic [2:0] P_PUSH = 3'd0, P_POP = 3'd1, P_ADD = 3'd2, P_SUB = 3'd3;
  localparam logic [2:0] P_TOP = 3'd4, P_CLR = 3'd5, P_INC = 3'd6, P_DEC = 3'd7;

  typedef struct {
    logic [2:0]        op;
    logic [WIDTH-1:0]  data;
    logic              err;
    logic              carry;
    logic [WIDTH-1:0]  dvr;
    logic [ADDR_W-1:0] dar;
    logic [CNT_W-1:0]  count;
    int                lat;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic [WIDTH-1:0]  dvr;
  logic [ADDR_W-1:0] dar;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  int checks = 0;
  int errors = 0;

  vec_t sb_q[$];
  vec_t tbl[19];

  stack_calc_core_if #(.WIDTH(WIDTH)) ifc ();

  stack_calc_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd_if (ifc.slave),
    .dvr    (dvr),
    .dar    (dar),
    .count  (count),
    .empty  (empty),
    .full   (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] data,
                              input logic err, input logic carry,
                              input logic [7:0] dv, input logic [6:0] da,
                              input logic [7:0] cnt, input int lat);
    vec_t v;
    v.op = op; v.data = data; v.err = err; v.carry = carry;
    v.dvr = dv; v.dar = da; v.count = cnt; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!ifc.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_before_issue", 32'(ifc.cmd_ready), 32'd1);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_data  = d;
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic run(input string tag, input vec_t v);
    vec_t e;
    int   lat = 0;
    bit   got = 0;
    sb_q.push_back(v);
    issue(v.op, v.data);
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ifc.rsp_valid) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no rsp_valid within %0d cycles", tag, lat);
      sb_q.delete();
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_lat"},   32'(lat),           32'(e.lat));
    chk({tag, "_err"},   32'(ifc.rsp_err),   32'(e.err));
    chk({tag, "_carry"}, 32'(ifc.rsp_carry), 32'(e.carry));
    chk({tag, "_dvr"},   32'(dvr),           32'(e.dvr));
    chk({tag, "_dar"},   32'(dar),           32'(e.dar));
    chk({tag, "_count"}, 32'(count),         32'(e.count));
    chk({tag, "_empty"}, 32'(empty),         32'(e.count == 0));
    chk({tag, "_full"},  32'(full),          32'(e.count == CNT_W'(DEPTH)));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(ifc.rsp_valid), 32'd0);
  endtask

  initial begin
    int seen;

    tbl[0]  = mk(P_PUSH, 8'h05, 0, 0, 8'h05, 7'h7F, 8'd1, 2);
    tbl[1]  = mk(P_PUSH, 8'h03, 0, 0, 8'h03, 7'h7E, 8'd2, 2);
    tbl[2]  = mk(P_ADD,  8'h00, 0, 0, 8'h08, 7'h7F, 8'd1, 5);
    tbl[3]  = mk(P_CLR,  8'h00, 0, 0, 8'h00, 7'h00, 8'd0, 1);
    tbl[4]  = mk(P_PUSH, 8'h03, 0, 0, 8'h03, 7'h7F, 8'd1, 2);
    tbl[5]  = mk(P_PUSH, 8'h05, 0, 0, 8'h05, 7'h7E, 8'd2, 2);
    tbl[6]  = mk(P_SUB,  8'h00, 0, 1, 8'hFE, 7'h7F, 8'd1, 5);
    tbl[7]  = mk(P_CLR,  8'h00, 0, 0, 8'h00, 7'h00, 8'd0, 1);
    tbl[8]  = mk(P_POP,  8'h00, 1, 0, 8'h00, 7'h00, 8'd0, 1);
    tbl[9]  = mk(P_PUSH, 8'h5A, 0, 0, 8'h5A, 7'h7F, 8'd1, 2);
    tbl[10] = mk(P_ADD,  8'h00, 1, 0, 8'h5A, 7'h7F, 8'd1, 1);
    tbl[11] = mk(P_TOP,  8'h00, 0, 0, 8'h5A, 7'h7F, 8'd1, 3);
    tbl[12] = mk(P_POP,  8'h00, 0, 0, 8'h00, 7'h00, 8'd0, 1);
    tbl[13] = mk(P_TOP,  8'h00, 1, 0, 8'h00, 7'h00, 8'd0, 1);
    tbl[14] = mk(P_PUSH, 8'hC0, 0, 0, 8'hC0, 7'h7F, 8'd1, 2);
    tbl[15] = mk(P_PUSH, 8'h50, 0, 0, 8'h50, 7'h7E, 8'd2, 2);
    tbl[16] = mk(P_ADD,  8'h00, 0, 1, 8'h10, 7'h7F, 8'd1, 5);
    tbl[17] = mk(P_PUSH, 8'h22, 0, 0, 8'h22, 7'h7E, 8'd2, 2);
    tbl[18] = mk(P_POP,  8'h00, 0, 0, 8'h10, 7'h7F, 8'd1, 3);

    rst_n         = 1'b0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 3'd0;
    ifc.cmd_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_count",     32'(count),         32'd0);
    chk("rst_dar",       32'(dar),           32'd0);
    chk("rst_dvr",       32'(dvr),           32'd0);
    chk("rst_empty",     32'(empty),         32'd1);
    chk("rst_full",      32'(full),          32'd0);
    chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);

    for (int i = 0; i < 19; i++) begin
      run($sformatf("vec%0d", i), tbl[i]);
    end

    // Fill the whole stack: value i lands at address DEPTH-1-i.
    run("t4_clr", mk(P_CLR, 8'h00, 0, 0, 8'h00, 7'h00, 8'd0, 1));
    for (int i = 0; i < DEPTH; i++) begin
      run($sformatf("t4_push%0d", i),
          mk(P_PUSH, 8'(i), 0, 0, 8'(i), 7'(DEPTH - 1 - i), 8'(i + 1), 2));
    end
    run("t4_ovf", mk(P_PUSH, 8'h99, 1, 0, 8'(DEPTH - 1), 7'h00, 8'(DEPTH), 1));
    run("t4_pop", mk(P_POP, 8'h00, 0, 0, 8'(DEPTH - 2), 7'h01, 8'(DEPTH - 1), 3));

    // dar walks off the stack and wraps; the raw RAM words come from the fill.
    run("t5_clr",  mk(P_CLR,  8'h00, 0, 0, 8'h00, 7'h00, 8'd0, 1));
    run("t5_push", mk(P_PUSH, 8'hAA, 0, 0, 8'hAA, 7'h7F, 8'd1, 2));
    run("t5_dec",  mk(P_DEC,  8'h00, 0, 0, 8'h01, 7'h7E, 8'd1, 3));
    run("t5_inc1", mk(P_INC,  8'h00, 0, 0, 8'hAA, 7'h7F, 8'd1, 3));
    run("t5_inc2", mk(P_INC,  8'h00, 0, 0, 8'h7F, 7'h00, 8'd1, 3));

    // Reset while ADD sits in RDB: the response must never appear.
    run("t6_push1", mk(P_PUSH, 8'h05, 0, 0, 8'h05, 7'h7E, 8'd2, 2));
    run("t6_push2", mk(P_PUSH, 8'h03, 0, 0, 8'h03, 7'h7D, 8'd3, 2));
    issue(P_ADD, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ifc.rsp_valid) seen++;
    end
    rst_n = 1'b1;
    chk("t6_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
    chk("t6_count",     32'(count),         32'd0);
    chk("t6_dar",       32'(dar),           32'd0);
    chk("t6_dvr",       32'(dvr),           32'd0);
    repeat (6) begin
      @(negedge clk);
      if (ifc.rsp_valid) seen++;
    end
    chk("t6_no_rsp", 32'(seen), 32'd0);
    run("t6_after", mk(P_PUSH, 8'h11, 0, 0, 8'h11, 7'h7F, 8'd1, 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
